// File: rtl/mul_unit_pkg.sv
// Shared core definitions for the M-extension multiply unit:
// the funct3 operation codes and the multiply pipeline depth.
package mul_unit_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    localparam int MUL_STAGES = 2;

    localparam int PP_W = 50;

    // rs1 is sign-extended for MULH/MULHSU, rs2 only for MULH.
    function automatic logic src_a_signed(input mul_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic src_b_signed(input mul_op_e op);
        return (op == OP_MULH);
    endfunction

endpackage

// File: rtl/mul_unit_if.sv
// Issue and result signals between the E stage and the multiply pipeline.
// The master drives the issued op and kill; the slave (mul_unit) returns stage status.
interface mul_unit_if
    import mul_unit_pkg::*;
#(
    parameter int ROB_IDX_W = 4
);
    logic                 mul_enE;
    mul_op_e              funct3E;
    logic [31:0]          srcAE;
    logic [31:0]          srcBE;
    logic [4:0]           r_WAE;
    logic [ROB_IDX_W-1:0] rob_tagE;
    logic                 kill;

    logic                 mul_en1E;
    logic                 mul_en2E;
    logic [4:0]           r_WA_MU1;
    logic [4:0]           r_WA_MU2;
    logic [ROB_IDX_W-1:0] rob_tag_MU2;
    logic [31:0]          mul_resultMU2;

    modport master (
        output mul_enE, funct3E, srcAE, srcBE, r_WAE, rob_tagE, kill,
        input  mul_en1E, mul_en2E, r_WA_MU1, r_WA_MU2, rob_tag_MU2, mul_resultMU2
    );

    modport slave (
        input  mul_enE, funct3E, srcAE, srcBE, r_WAE, rob_tagE, kill,
        output mul_en1E, mul_en2E, r_WA_MU1, r_WA_MU2, rob_tag_MU2, mul_resultMU2
    );
endinterface

// File: rtl/mul_pp_gen.sv
// Operand extension to 33 bits and the two partial products of the MU1 stage.
// Split point is b[15:0] (unsigned) and b[32:16] (signed 17-bit).
module mul_pp_gen
    import mul_unit_pkg::*;
(
    input  logic [31:0]     srcA,
    input  logic [31:0]     srcB,
    input  mul_op_e         funct3,
    output logic [PP_W-1:0] P0,
    output logic [PP_W-1:0] P1
);
    logic [32:0]     a;
    logic [32:0]     b;
    logic [PP_W-1:0] a_ext;
    logic [PP_W-1:0] b_lo_ext;
    logic [PP_W-1:0] b_hi_ext;

    // Sign-extend to the full product width so a plain modular multiply
    // yields the correct two's-complement partial product.
    always_comb begin
        a        = {src_a_signed(funct3) & srcA[31], srcA};
        b        = {src_b_signed(funct3) & srcB[31], srcB};
        a_ext    = {{(PP_W-33){a[32]}}, a};
        b_lo_ext = {{(PP_W-16){1'b0}}, b[15:0]};
        b_hi_ext = {{(PP_W-17){b[32]}}, b[32:16]};
        P0       = a_ext * b_lo_ext;
        P1       = a_ext * b_hi_ext;
    end

endmodule

// File: rtl/mul_unit.sv
// Two-stage RISC-V M-extension multiplier: MU1 registers the partial products,
// MU2 sums them and registers the selected 32-bit half. One op per cycle, no stalls.
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int ROB_IDX_W = 4
)(
    input logic       clk,
    input logic       rst,
    mul_unit_if.slave bus
);
    logic [MUL_STAGES-1:0] valid;
    logic                  accept;
    logic                  advance;

    mul_op_e               op_mu1;
    logic [4:0]            rd_mu1;
    logic [ROB_IDX_W-1:0]  tag_mu1;
    logic [PP_W-1:0]       p0_mu1;
    logic [PP_W-1:0]       p1_mu1;

    logic [4:0]            rd_mu2;
    logic [ROB_IDX_W-1:0]  tag_mu2;
    logic [31:0]           result_mu2;

    logic [PP_W-1:0]       p0_e;
    logic [PP_W-1:0]       p1_e;
    logic [63:0]           product;
    logic [31:0]           result_d;

    mul_pp_gen u_pp_gen (
        .srcA   (bus.srcAE),
        .srcB   (bus.srcBE),
        .funct3 (bus.funct3E),
        .P0     (p0_e),
        .P1     (p1_e)
    );

    assign accept  = bus.mul_enE & ~bus.kill;
    assign advance = valid[0] & ~bus.kill;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else begin
            valid <= {advance, accept};
        end
    end

    // NOTE: data registers are reset too because their values are visible
    // outputs that must read 0 after reset, not only the valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_mu1  <= OP_MUL;
            rd_mu1  <= '0;
            tag_mu1 <= '0;
            p0_mu1  <= '0;
            p1_mu1  <= '0;
        end else if (accept) begin
            op_mu1  <= bus.funct3E;
            rd_mu1  <= bus.r_WAE;
            tag_mu1 <= bus.rob_tagE;
            p0_mu1  <= p0_e;
            p1_mu1  <= p1_e;
        end
    end

    // Only bits [63:0] of the 66-bit sum P0 + (P1 << 16) are ever selected.
    // NOTE: every always_comb output is assigned on all paths to avoid latches.
    always_comb begin
        product  = 64'({{(66-PP_W){p0_mu1[PP_W-1]}}, p0_mu1} + {p1_mu1, 16'b0});
        result_d = (op_mu1 == OP_MUL) ? product[31:0] : product[63:32];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_mu2     <= '0;
            tag_mu2    <= '0;
            result_mu2 <= '0;
        end else if (advance) begin
            rd_mu2     <= rd_mu1;
            tag_mu2    <= tag_mu1;
            result_mu2 <= result_d;
        end
    end

    assign bus.mul_en1E      = valid[0];
    assign bus.mul_en2E      = valid[1];
    assign bus.r_WA_MU1      = rd_mu1;
    assign bus.r_WA_MU2      = rd_mu2;
    assign bus.rob_tag_MU2   = tag_mu2;
    assign bus.mul_resultMU2 = result_mu2;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed vectors, pipeline corner sequences
// and a randomized run against a 64-bit arithmetic reference model.
module tb_mul_unit;
    import mul_unit_pkg::*;

    localparam int TAG_W = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mul_unit_if #(.ROB_IDX_W(TAG_W)) bus ();

    mul_unit #(.ROB_IDX_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        mul_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    // Reference: full 64-bit product of the operands interpreted per op.
    function automatic logic [31:0] ref_mul(input mul_op_e op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        longint p;
        sa = (op == OP_MULH || op == OP_MULHSU) ? longint'($signed(a)) : longint'({32'b0, a});
        sb = (op == OP_MULH) ? longint'($signed(b)) : longint'({32'b0, b});
        p  = sa * sb;
        return (op == OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: the op accepted at the previous edge (now expected in MU1).
    logic        m_acc;
    mul_op_e     m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [4:0]  m_rd;
    logic [3:0]  m_tag;

    task automatic step(input logic en, input mul_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [3:0] tag, input logic kl);
        logic acc;
        logic v2;
        @(negedge clk);
        bus.mul_enE  = en;
        bus.funct3E  = op;
        bus.srcAE    = a;
        bus.srcBE    = b;
        bus.r_WAE    = rd;
        bus.rob_tagE = tag;
        bus.kill     = kl;
        @(posedge clk);
        #1;
        acc = en & ~kl;
        v2  = m_acc & ~kl;
        check("mul_en1E", bus.mul_en1E, acc);
        if (acc) check("r_WA_MU1", bus.r_WA_MU1, rd);
        check("mul_en2E", bus.mul_en2E, v2);
        if (v2) begin
            check("r_WA_MU2", bus.r_WA_MU2, m_rd);
            check("rob_tag_MU2", bus.rob_tag_MU2, m_tag);
            check("mul_resultMU2", bus.mul_resultMU2, ref_mul(m_op, m_a, m_b));
        end
        m_acc = acc;
        m_op  = op;
        m_a   = a;
        m_b   = b;
        m_rd  = rd;
        m_tag = tag;
    endtask

    task automatic idle();
        step(1'b0, OP_MUL, 32'h0, 32'h0, 5'd0, 4'd0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag_name);
        check({tag_name, " mul_en1E"}, bus.mul_en1E, 0);
        check({tag_name, " mul_en2E"}, bus.mul_en2E, 0);
        check({tag_name, " r_WA_MU1"}, bus.r_WA_MU1, 0);
        check({tag_name, " r_WA_MU2"}, bus.r_WA_MU2, 0);
        check({tag_name, " rob_tag_MU2"}, bus.rob_tag_MU2, 0);
        check({tag_name, " mul_resultMU2"}, bus.mul_resultMU2, 0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corner[4];
        corner[0] = 32'h8000_0000;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h0000_0000;
        if ($urandom_range(0, 7) == 0) return corner[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        m_acc  = 1'b0;
        m_op   = OP_MUL;
        m_a    = '0;
        m_b    = '0;
        m_rd   = '0;
        m_tag  = '0;

        vecs[0] = '{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1] = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2] = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3] = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4] = '{OP_MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
        vecs[5] = '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[6] = '{OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[7] = '{OP_MULHU,  32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
        vecs[8] = '{OP_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
        vecs[9] = '{OP_MULHSU, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFE};

        bus.mul_enE  = 1'b0;
        bus.funct3E  = OP_MUL;
        bus.srcAE    = '0;
        bus.srcBE    = '0;
        bus.r_WAE    = '0;
        bus.rob_tagE = '0;
        bus.kill     = 1'b0;
        rst          = 1'b1;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors: issue, let the op reach MU2, compare to the table.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), 4'(i), 1'b0);
            idle();
            check("vec mul_en2E", bus.mul_en2E, 1);
            check("vec result", bus.mul_resultMU2, vecs[i].exp);
            idle();
        end

        // Four back-to-back ops on rd=1..4, results in order one per cycle.
        for (int k = 0; k < 6; k++) begin
            if (k < 4)
                step(1'b1, mul_op_e'(k), pick_operand(), pick_operand(), 5'(k + 1), 4'(k), 1'b0);
            else
                idle();
            if (k >= 1 && k <= 4) begin
                check("b2b mul_en2E", bus.mul_en2E, 1);
                check("b2b r_WA_MU2", bus.r_WA_MU2, k);
            end
        end
        check("b2b drained", bus.mul_en2E, 0);

        // Kill with both stages full and a new op presented: nothing survives.
        step(1'b1, OP_MULH, 32'h1234_5678, 32'h9ABC_DEF0, 5'd5, 4'd5, 1'b0);
        step(1'b1, OP_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd6, 4'd6, 1'b0);
        step(1'b1, OP_MUL, 32'h0000_0003, 32'h0000_0004, 5'd7, 4'd7, 1'b1);
        check("kill mul_en1E", bus.mul_en1E, 0);
        check("kill mul_en2E", bus.mul_en2E, 0);
        idle();
        check("kill no result", bus.mul_en2E, 0);

        // Asynchronous reset between edges with both stages valid.
        step(1'b1, OP_MULHSU, 32'hFFFF_0000, 32'h0001_0000, 5'd8, 4'd8, 1'b0);
        step(1'b1, OP_MUL, 32'h0000_0010, 32'h0000_0010, 5'd9, 4'd9, 1'b0);
        #1 rst = 1'b1;
        #1 check_all_zero("midrst");
        #1 rst = 1'b0;
        m_acc = 1'b0;
        step(1'b1, OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd10, 4'd10, 1'b0);
        idle();
        check("post-rst result", bus.mul_resultMU2, 32'hFFFF_FFEB);

        // Destination x0 is an ordinary op.
        step(1'b1, OP_MULHU, 32'hFFFF_FFFF, 32'h0000_0010, 5'd0, 4'd3, 1'b0);
        idle();
        check("x0 mul_en2E", bus.mul_en2E, 1);
        check("x0 result", bus.mul_resultMU2, 32'h0000_000F);

        // Random traffic with idle cycles and occasional kills.
        for (int n = 0; n < 10000; n++) begin
            step($urandom_range(0, 9) != 0, mul_op_e'($urandom_range(0, 3)),
                 pick_operand(), pick_operand(), 5'($urandom), 4'($urandom),
                 $urandom_range(0, 31) == 0);
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_unit.md
MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 SHALL have parameter ROB_IDX_W, default 4: width of the ROB tag carried with each op.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port mul_enE  input  1  a valid M-extension multiply is in E this cycle.
REQ-005 SHALL have port funct3E  input  2  multiply op: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-006 SHALL have port srcAE, srcBE  input  32  forwarded rs1/rs2 operands.
REQ-007 SHALL have port r_WAE  input  5  destination register of the E op.
REQ-008 SHALL have port rob_tagE  input  ROB_IDX_W  ROB entry of the E op.
REQ-009 SHALL have port kill  input  1  squash all in-flight and incoming multiplies (mispredict/exception).
REQ-010 SHALL have ports mul_en1E, mul_en2E  output  1  valid bits of stages MU1 and MU2.
REQ-011 SHALL have ports r_WA_MU1, r_WA_MU2  output  5  destination register held in MU1 and MU2.
REQ-012 SHALL have port rob_tag_MU2  output  ROB_IDX_W  ROB tag of the MU2 result.
REQ-013 SHALL have port mul_resultMU2  output  32  final result, meaningful only when mul_en2E=1.

Function
REQ-014 SHALL be a 2-stage pipeline (MU1, MU2) that accepts one op per cycle with no back-pressure; issue is E-stage only.
REQ-015 SHALL capture on a rising edge when mul_enE=1 and kill=0: MU1 valid <= 1, plus funct3, r_WAE and rob_tagE.
REQ-016 SHALL sign-extend each operand to 33 bits before multiplying.
  - srcAE: signed for MULH and MULHSU, unsigned otherwise.
  - srcBE: signed for MULH only.
  - MUL ignores signedness, since the low 32 bits are identical either way.
REQ-017 SHALL compute the MU1 partial products from the extended operands a and b and register them: P0 = a x b[15:0] (b[15:0] unsigned), P1 = a x b[32:16] (signed 17-bit).
REQ-018 SHALL form the 66-bit signed product in MU2 as P0 + (P1 << 16), then register mul_resultMU2 as:
  - MUL: product bits [31:0];
  - MULH, MULHSU, MULHU: product bits [63:32].
REQ-019 SHALL advance MU1 to MU2 every cycle: mul_en2E <= mul_en1E & ~kill, with r_WA_MU2 and rob_tag_MU2 following.
REQ-020 SHALL have a latency of exactly 2 cycles: an op accepted at edge N has mul_en1E=1 in cycle N+1 and mul_en2E=1 with its result in cycle N+2.
REQ-021 SHALL clear mul_en1E and mul_en2E at the next edge when kill=1 and SHALL drop any simultaneous mul_enE op; data registers are don't-care.
REQ-022 SHALL hold the address and tag outputs of a stage stable and equal to the op's values while that stage's valid bit is 1.
REQ-023 SHALL treat a destination of x0 as a normal op; suppressing the writeback belongs to the consumer.
REQ-024 SHALL sustain back-to-back ops with every result in order, one per cycle.

Reset
REQ-025 SHALL clear mul_en1E and mul_en2E asynchronously when rst=1, including mid-operation.
REQ-026 SHALL drive r_WA_MU1, r_WA_MU2, rob_tag_MU2 and mul_resultMU2 to 0 on reset.
REQ-027 SHALL accept its first op at the first rising edge after rst deasserts.

Structure
REQ-028 SHALL take the funct3 multiply codes (MUL/MULH/MULHSU/MULHU) and the stage count from the shared core package.
REQ-029 SHALL place the operand-extension and partial-product logic in sub-module mul_pp_gen.
  - Inputs: srcA, srcB, funct3.
  - Outputs: P0, P1.
  - Purely combinational.
REQ-030 SHALL keep the MU1/MU2 pipeline registers and valid bits in mul_unit itself.

Verification
REQ-031 SHALL cover MUL with srcA=7, srcB=0xFFFFFFFD -> mul_en2E=1 two cycles later, result 0xFFFFFFEB.
REQ-032 SHALL cover MULH with srcA=srcB=0x80000000 -> 0x40000000; MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU with 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-033 SHALL cover four back-to-back ops on rd=1..4 -> mul_en2E high for 4 consecutive cycles, r_WA_MU2 = 1,2,3,4 in order, correct results.
REQ-034 SHALL cover kill asserted while ops sit in MU1 and MU2 and a new mul_enE is presented -> mul_en1E=mul_en2E=0 next cycle, no result emitted.
REQ-035 SHALL cover rst pulsed between edges while both stages are valid -> valid bits drop immediately and all outputs read 0.
REQ-036 SHALL cover a random compare of 10k ops of all four types against a 64-bit reference model -> zero mismatches.
